// File: rtl/posit_encode.sv
// posit_encode: two-stage pipelined posit packer (inverse of the normalise stage).
//   S1 builds {regime, exponent, fraction}, left-aligns it and registers the
//   body plus guard/sticky and the special-case flags. S2 rounds, applies the
//   minpos floor, the special cases and two's-complement negation, and holds
//   the packed word in the output register.
// Optional feature macro: FRIC_ENC_RNE_EN (round-to-nearest-even). When it is
//   undefined the body is truncated and no guard/sticky state exists.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready has no path from in_valid)
//   in_sign, in_nar     result sign, force NaR
//   in_regime           signed regime k; most-negative value encodes zero
//   in_exponent         exponent, bits [EN-1:0] used
//   in_mantissa         fraction, MSB-aligned, hidden 1 removed
//   out_valid/out_ready output handshake
//   out_posit           packed posit, WIDTH+1 bits
module posit_encode #(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int W_REG = $clog2(WIDTH) + 1,
    parameter int W_EXP = $clog2(WIDTH) + 1,
    parameter int W_MAN = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic             in_nar,
    input  logic [W_REG-1:0] in_regime,
    input  logic [W_EXP-1:0] in_exponent,
    input  logic [W_MAN-1:0] in_mantissa,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_posit
);

    localparam int B  = 2 * WIDTH + EN + 2;   // alignment buffer width
    localparam int RW = EN + W_MAN;           // exponent + fraction width

    localparam logic signed [W_REG-1:0] K_MAX  = W_REG'(WIDTH - 1);
    localparam logic signed [W_REG-1:0] K_MIN  = W_REG'(-WIDTH);
    localparam logic        [W_REG-1:0] K_ZERO = {1'b1, {(W_REG-1){1'b0}}};
    localparam logic        [WIDTH-1:0] MINPOS = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, out_valid_q;
    logic s2_adv, s1_adv;

    assign s2_adv   = !out_valid_q | out_ready;
    assign s1_adv   = !s1_valid_q | s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = out_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: regime run-length build and alignment
    // ------------------------------------------------------------------
    logic signed [W_REG-1:0] k;
    logic        [W_REG:0]   kx, rlen, rlen_m1;
    logic                    k_neg;
    logic        [B-1:0]     head, tail, bufv;
    logic        [RW-1:0]    rem;
    logic                    zero_d, sat_max_d, sat_min_d, sat_d;
    logic        [WIDTH-1:0] body_d;
    logic                    guard_d, sticky_d;

    assign k      = $signed(in_regime);
    assign k_neg  = in_regime[W_REG-1];
    assign kx     = {in_regime[W_REG-1], in_regime};
    // k >= 0: k+2 bits; k < 0: -k+1 bits (computed as ~kx + 2)
    assign rlen    = k_neg ? (~kx + (W_REG+1)'(2)) : (kx + (W_REG+1)'(2));
    assign rlen_m1 = rlen - (W_REG+1)'(1);
    assign rem     = {in_exponent[EN-1:0], in_mantissa};

    assign zero_d    = (in_regime == K_ZERO);
    assign sat_max_d = (k >= K_MAX);
    assign sat_min_d = (k <= K_MIN) & !zero_d;
    assign sat_d     = sat_max_d | sat_min_d;

    always_comb begin
        // Positive regime: rlen-1 leading ones; the terminating zero is the gap
        // left by shifting the tail one bit further. Negative: a single one
        // after rlen-1 zeros.
        if (k_neg) head = {1'b1, {(B-1){1'b0}}} >> rlen_m1;
        else       head = ~({B{1'b1}} >> rlen_m1);
        tail = {rem, {(B-RW){1'b0}}} >> rlen;
        bufv = head | tail;

        body_d   = bufv[B-1 -: WIDTH];
        guard_d  = bufv[B-1-WIDTH];
        sticky_d = |bufv[B-2-WIDTH:0];
        if (sat_max_d) begin
            body_d   = {WIDTH{1'b1}};
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end else if (sat_min_d) begin
            body_d   = MINPOS;
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end
    end

    logic             s1_sign_q, s1_nar_q, s1_zero_q, s1_sat_q;
    logic [WIDTH-1:0] s1_body_q;
`ifdef FRIC_ENC_RNE_EN
    logic             s1_guard_q, s1_sticky_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_sat_q    <= 1'b0;
            s1_body_q   <= '0;
`ifdef FRIC_ENC_RNE_EN
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= in_sign;
                s1_nar_q    <= in_nar;
                s1_zero_q   <= zero_d;
                s1_sat_q    <= sat_d;
                s1_body_q   <= body_d;
`ifdef FRIC_ENC_RNE_EN
                s1_guard_q  <= guard_d;
                s1_sticky_q <= sticky_d;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, minpos floor, specials, negation
    // ------------------------------------------------------------------
    logic             rnd_up;
    logic [WIDTH-1:0] body_r;
    logic [WIDTH:0]   word_d;

`ifdef FRIC_ENC_RNE_EN
    // No rounding past maxpos: an all-ones body would carry into the sign.
    assign rnd_up = s1_guard_q & (s1_sticky_q | s1_body_q[0]) & ~(&s1_body_q) & ~s1_sat_q;
`else
    logic unused_gs;
    assign unused_gs = guard_d ^ sticky_d ^ s1_sat_q;
    assign rnd_up    = 1'b0;
`endif

    always_comb begin
        body_r = s1_body_q + WIDTH'(rnd_up);
        if (body_r == '0) body_r = MINPOS;   // nonzero values never pack to zero
        word_d = {1'b0, body_r};
        if (s1_sign_q) word_d = ~word_d + (WIDTH+1)'(1);
        if (s1_nar_q)       word_d = {1'b1, {WIDTH{1'b0}}};
        else if (s1_zero_q) word_d = '0;
    end

    logic [WIDTH:0] out_posit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) out_posit_q <= word_d;
        end
    end

    assign out_posit = out_posit_q;

    logic unused_exp_hi;
    assign unused_exp_hi = ^in_exponent[W_EXP-1:EN];

endmodule

// File: tb/tb_posit_encode.sv
module tb_posit_encode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sign = 1'b0;
    logic       in_nar = 1'b0;
    logic [3:0] in_regime = 4'h0;
    logic [3:0] in_exponent = 4'h0;
    logic [6:0] in_mantissa = 7'h0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_posit;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    posit_encode dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_nar(in_nar),
        .in_regime(in_regime), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
        .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
    );

    task automatic drive(input logic s, input logic nar, input logic [3:0] k,
                         input logic [3:0] e, input logic [6:0] m);
        in_sign = s; in_nar = nar; in_regime = k; in_exponent = e; in_mantissa = m;
    endtask

    // Single operand through an idle pipe; lat = edges after the accepting
    // edge until out_valid is seen (-1 on timeout).
    task automatic apply(input logic s, input logic nar, input logic [3:0] k,
                         input logic [3:0] e, input logic [6:0] m,
                         output logic [7:0] res, output int lat);
        bit seen;
        @(negedge clk);
        out_ready = 1'b1;
        drive(s, nar, k, e, m);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; res = 8'h00; seen = 0;
        for (int c = 0; c <= 8; c++) begin
            if (!seen) begin
                if (c > 0) begin @(posedge clk); #1; end
                if (out_valid) begin lat = c; res = out_posit; seen = 1; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_posit !== 8'h00) begin n_fail++; $display("FAIL reset_out_posit got %h want 00", out_posit); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_unity;
        logic [7:0] r; int lat;
        apply(1'b0, 1'b0, 4'h0, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'h40) begin n_fail++; $display("FAIL unity_pos got %h want 40", r); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unity_latency got %0d want 1", lat); end
        apply(1'b1, 1'b0, 4'h0, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'hC0) begin n_fail++; $display("FAIL unity_neg got %h want c0", r); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unity_neg_latency got %0d want 1", lat); end
    endtask

    task automatic test_packing;
        logic [7:0] r; int lat;
        apply(1'b0, 1'b0, 4'h1, 4'h1, 7'b1000000, r, lat);
        n_checks++; if (r !== 8'h6C) begin n_fail++; $display("FAIL pack_k1 got %h want 6c", r); end
        apply(1'b0, 1'b0, 4'hE, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'h10) begin n_fail++; $display("FAIL pack_km2 got %h want 10", r); end
    endtask

    task automatic test_saturation;
        logic [7:0] r; int lat;
        apply(1'b0, 1'b0, 4'h6, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'h7F) begin n_fail++; $display("FAIL sat_k6 got %h want 7f", r); end
        apply(1'b0, 1'b0, 4'h7, 4'h1, 7'h7F, r, lat);
        n_checks++; if (r !== 8'h7F) begin n_fail++; $display("FAIL sat_k7 got %h want 7f", r); end
        apply(1'b0, 1'b0, 4'h9, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'h01) begin n_fail++; $display("FAIL sat_km7 got %h want 01", r); end
        apply(1'b1, 1'b0, 4'h9, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'hFF) begin n_fail++; $display("FAIL sat_km7_neg got %h want ff", r); end
        apply(1'b1, 1'b0, 4'h8, 4'h1, 7'h55, r, lat);
        n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL zero got %h want 00", r); end
        apply(1'b0, 1'b1, 4'h8, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'h80) begin n_fail++; $display("FAIL nar_zero_regime got %h want 80", r); end
        apply(1'b1, 1'b1, 4'h2, 4'h1, 7'h12, r, lat);
        n_checks++; if (r !== 8'h80) begin n_fail++; $display("FAIL nar_normal got %h want 80", r); end
    endtask

    task automatic test_rounding;
        logic [7:0] r; int lat;
        logic [7:0] exp_up;
`ifdef FRIC_ENC_RNE_EN
        exp_up = 8'h7F;
`else
        exp_up = 8'h7E;
`endif
        apply(1'b0, 1'b0, 4'h5, 4'h1, 7'b0000001, r, lat);
        n_checks++; if (r !== exp_up) begin n_fail++; $display("FAIL round_up got %h want %h", r, exp_up); end
        apply(1'b0, 1'b0, 4'h5, 4'h1, 7'h00, r, lat);
        n_checks++; if (r !== 8'h7E) begin n_fail++; $display("FAIL round_tie_even got %h want 7e", r); end
        apply(1'b0, 1'b0, 4'h4, 4'h1, 7'h00, r, lat);
        n_checks++; if (r !== 8'h7D) begin n_fail++; $display("FAIL round_k4 got %h want 7d", r); end
    endtask

    task automatic test_backpressure;
        logic [3:0] ks [4];
        logic       ss [4];
        logic [7:0] want [4];
        logic [7:0] got [$];
        logic [7:0] held;
        bit         stalled;
        int         acc;
        ks = '{4'h0, 4'h0, 4'h1, 4'hE};
        ss = '{1'b0, 1'b1, 1'b0, 1'b0};
        want = '{8'h40, 8'hC0, 8'h6C, 8'h10};
        acc = 0; stalled = 0; held = 8'h00;
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            if (acc < 4) begin
                drive(ss[acc], 1'b0, ks[acc], (acc == 2) ? 4'h1 : 4'h0,
                      (acc == 2) ? 7'b1000000 : 7'h00);
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (cyc == 2) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
                n_checks++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepts_before_full got %0d want 2", acc); end
            end
            if (stalled && out_valid) begin
                n_checks++; if (out_posit !== held) begin n_fail++; $display("FAIL bp_stall_stable got %h want %h", out_posit, held); end
            end
            stalled = out_valid && !out_ready;
            if (stalled) held = out_posit;
            if (out_valid && out_ready) got.push_back(out_posit);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got.size()); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                n_checks++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], want[i]); end
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [7:0] r; int lat;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 4'h1, 4'h1, 7'h40);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_full got v=%b r=%b want v=1 r=0", out_valid, in_ready); end
        rst = 1'b1; #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flushed got %b want 0", out_valid); end
        apply(1'b0, 1'b0, 4'h0, 4'h0, 7'h00, r, lat);
        n_checks++; if (r !== 8'h40) begin n_fail++; $display("FAIL rst_mid_first got %h want 40", r); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rst_mid_latency got %0d want 1", lat); end
    endtask

    initial begin
        test_reset;
        test_unity;
        test_packing;
        test_saturation;
        test_rounding;
        test_backpressure;
        test_reset_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
